// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the RAM arbiter
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU   = 1'b1;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - winner selection; RAM_ARB_ROUND_ROBIN_EN picks round-robin over fixed priority
module ram_arb_pick (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_winner
);
  import ram_arb_pkg::*;

  // Single requester always wins; a tie is resolved by the build-selected policy.
  // With no request the last grant is echoed so the output never floats.
  always_comb begin
    o_winner = i_last_grant;
    if (i_req0 && i_req1) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      o_winner = ~i_last_grant;
`else
      o_winner = PORT_LSU;
`endif
    end else if (i_req1) begin
      o_winner = PORT_LSU;
    end else if (i_req0) begin
      o_winner = PORT_FETCH;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port arbiter/sequencer in front of the single-port RAM; option RAM_ARB_ROUND_ROBIN_EN
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wr,
  input  logic              ram_response,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy,
  output logic              grant
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_grant;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              w_any_req;
  logic              w_winner;
  logic              w_last;
  logic              w_start;
  logic              w_finish;

  assign w_any_req = req0 | req1;
  assign w_start   = (r_state == IDLE) && w_any_req;
  assign w_finish  = (r_state == ACCESS) && (r_cnt == '0) && ram_response;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic r_ptr;

  // Round-robin pointer: remembers the last winner, starts at 1 so port 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b1;
    end else if (w_start) begin
      r_ptr <= w_winner;
    end
  end

  assign w_last = r_ptr;
`else
  assign w_last = r_grant;
`endif

  ram_arb_pick u_pick (
    .i_req0       (req0),
    .i_req1       (req1),
    .i_last_grant (w_last),
    .o_winner     (w_winner)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: ACCESS holds until the settle window has elapsed and the RAM responds
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = ACCESS;
      ACCESS:  if (w_finish)  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Latch the winning request, run the settle counter and capture read data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_grant  <= PORT_FETCH;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (w_start) begin
        r_grant <= w_winner;
        r_wr    <= w_winner ? wr1 : wr0;
        r_addr  <= w_winner ? addr1 : addr0;
        r_wdata <= w_winner ? wdata1 : wdata0;
        r_cnt   <= CNT_LOAD;
      end else if (r_state == ACCESS && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_finish && !r_wr) begin
        if (r_grant == PORT_LSU) begin
          r_rdata1 <= ram_out;
        end else begin
          r_rdata0 <= ram_out;
        end
      end
    end
  end

  // Outputs: bus always mirrors the latch, strobes depend only on state
  always_comb begin
    ram_addr = r_addr;
    ram_data = r_wdata;
    ram_wr   = (r_state == ACCESS) && r_wr;
    busy     = (r_state != IDLE);
    ack0     = (r_state == DONE) && (r_grant == PORT_FETCH);
    ack1     = (r_state == DONE) && (r_grant == PORT_LSU);
    grant    = r_grant;
    rdata0   = r_rdata0;
    rdata1   = r_rdata1;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with a transaction-level reference model
module tb_ram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_wr;
  logic          ram_response;
  logic [DW-1:0] ram_out;
  logic          busy, grant;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wr(ram_wr),
    .ram_response(ram_response), .ram_out(ram_out),
    .busy(busy), .grant(grant)
  );

  // Simple RAM: writes land on any edge with wr high, reads are combinational
  logic [DW-1:0] ram_mem [16];
  always @(posedge clk) if (ram_wr) ram_mem[ram_addr[3:0]] <= ram_data;
  assign ram_out = ram_mem[ram_addr[3:0]];

  typedef struct {
    bit            port;
    bit            is_wr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  exp_t          m_e;
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] ref_mem [16];
  bit            exp_last = 1'b1;
  logic [DW-1:0] sh_rd0 = '0;
  logic [DW-1:0] sh_rd1 = '0;
  bit            resp_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arbitration policy: single requester wins, ties by build policy
  function automatic bit model_pick(input bit r0, input bit r1);
    bit w;
    if (r0 && r1) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      w = ~exp_last;
`else
      w = 1'b1;
`endif
    end else begin
      w = r1;
    end
    exp_last = w;
    return w;
  endfunction

  function automatic void push_exp(input bit port, input bit wr, input logic [3:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.port  = port;
    e.is_wr = wr;
    if (wr) begin
      ref_mem[a] = d;
      e.data = d;
    end else begin
      e.data = ref_mem[a];
    end
    sb.push_back(e);
  endfunction

  // Monitor: every ack pops one expected transaction
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_wr) check("ram_wr_outside_access", {31'b0, busy & ~ack0 & ~ack1}, 32'd1);
      if (ack0 || ack1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ack: ack0=%0b ack1=%0b with no access pending", ack0, ack1);
        end else begin
          m_e = sb.pop_front();
          check("ack_onehot", {31'b0, ack0 & ack1}, 32'd0);
          check("ack_port", {31'b0, ack1}, {31'b0, m_e.port});
          check("grant", {31'b0, grant}, {31'b0, m_e.port});
          if (!m_e.is_wr) begin
            if (m_e.port) sh_rd1 = m_e.data;
            else          sh_rd0 = m_e.data;
          end
          check("rdata0", rdata0, sh_rd0);
          check("rdata1", rdata1, sh_rd1);
        end
      end
    end
  end

  task automatic run_round(input bit r0, input bit r1, input bit w0, input bit w1,
                           input logic [3:0] a0, input logic [3:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1, input bit chk_lat);
    bit win, p0, p1;
    int cyc, first, second;
    @(negedge clk);
    win = model_pick(r0, r1);
    if (win) push_exp(1'b1, w1, a1, d1);
    else     push_exp(1'b0, w0, a0, d0);
    if (r0 && r1) begin
      exp_last = ~win;
      if (win) push_exp(1'b0, w0, a0, d0);
      else     push_exp(1'b1, w1, a1, d1);
    end
    req0 = r0; wr0 = w0; addr0 = AW'(a0); wdata0 = d0;
    req1 = r1; wr1 = w1; addr1 = AW'(a1); wdata1 = d1;
    p0 = r0; p1 = r1; cyc = 0; first = -1; second = -1;
    while ((p0 || p1) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ack0 && p0) begin
        req0 = 1'b0; p0 = 1'b0;
        if (first < 0) first = cyc; else second = cyc;
      end
      if (ack1 && p1) begin
        req1 = 1'b0; p1 = 1'b0;
        if (first < 0) first = cyc; else second = cyc;
      end
      if (resp_rand) ram_response = ($urandom_range(0, 3) != 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    if (p0 || p1) check("round_timeout", 32'd1, 32'd0);
    if (chk_lat) begin
      check("ack_latency", 32'(first), 32'(WC + 1));
      if (r0 && r1) check("back_to_back_gap", 32'(second - first), 32'(WC + 2));
    end
  endtask

  initial begin
    int acks, cyc;
    bit w;
    logic [DW-1:0] d;
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    ram_mem[5] = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;
    rst = 1'b1; req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; ram_response = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ack0", {31'b0, ack0}, 32'd0);
    check("rst_ack1", {31'b0, ack1}, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_data", ram_data, 32'd0);
    check("rst_ram_wr", {31'b0, ram_wr}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_grant", {31'b0, grant}, 32'd0);

    // Directed: read DEADBEEF, write then read back, tied-high response
    run_round(1, 0, 0, 0, 4'd5, 4'd0, '0, '0, 1);
    run_round(0, 1, 0, 1, 4'd0, 4'd9, '0, 32'h12345678, 1);
    run_round(1, 0, 0, 0, 4'd9, 4'd0, '0, '0, 1);
    run_round(1, 1, 0, 0, 4'd1, 4'd2, '0, '0, 1);

    // Stall: response low after the counter expires, address change ignored
    @(negedge clk);
    ram_response = 1'b0;
    void'(model_pick(1, 0));
    push_exp(1'b0, 1'b0, 4'd3, '0);
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'd3;
    repeat (WC) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k == 0) addr0 = 32'd7;
      @(negedge clk);
      check("stall_busy", {31'b0, busy}, 32'd1);
      check("stall_ram_addr", ram_addr, 32'd3);
      check("stall_no_ack", {31'b0, ack0}, 32'd0);
    end
    ram_response = 1'b1;
    @(negedge clk);
    check("stall_ack_after_response", {31'b0, ack0}, 32'd1);
    req0 = 1'b0;

    // Reset in the second ACCESS cycle of a write
    @(negedge clk);
    d = $urandom;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 32'd12; wdata1 = d;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_ram_wr", {31'b0, ram_wr}, 32'd0);
    check("midrst_ack", {30'b0, ack1, ack0}, 32'd0);
    check("midrst_grant", {31'b0, grant}, 32'd0);
    check("midrst_ram_addr", ram_addr, 32'd0);
    check("midrst_rdata0", rdata0, 32'd0);
    req1 = 1'b0; wr1 = 1'b0;
    ref_mem[12] = d;
    sh_rd0 = '0; sh_rd1 = '0; exp_last = 1'b1;
    rst = 1'b0;

    // Both requests held continuously for four accesses
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      w = model_pick(1, 1);
      push_exp(w, 1'b0, w ? 4'd2 : 4'd1, '0);
    end
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'd1;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 32'd2;
    acks = 0; cyc = 0;
    while (acks < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) acks++;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("hold_ack_count", 32'(acks), 32'd4);

    // Randomized traffic with a randomly stalling RAM
    resp_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int pat;
      pat = $urandom_range(1, 3);
      run_round(pat[0], pat[1], 1'($urandom), 1'($urandom),
                4'($urandom), 4'($urandom), $urandom, $urandom, 0);
    end
    resp_rand = 1'b0;
    ram_response = 1'b1;
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer in front of the single-port `ram` block. It shares the RAM between an instruction-fetch requester (port 0) and a load/store requester (port 1). It latches the winning request, holds the RAM bus stable for the required settling window, waits for the RAM `response`, then returns read data with a one-cycle acknowledge. All RAM traffic in the core goes through this block.

## Interface
Parameters:
- `ADDR_W`, 32, width of request and RAM addresses.
- `DATA_W`, 32, data width.
- `WAIT_CYCLES`, 2, minimum cycles the RAM bus is held per access; legal values are 1 and above.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  request from port 0 / port 1.
- `wr0` / `wr1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  ADDR_W  request address.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `rdata0` / `rdata1`  out  DATA_W  registered read data, valid from `ack` onward.
- `ram_addr`  out  ADDR_W  to RAM `addr`.
- `ram_data`  out  DATA_W  to RAM `data`.
- `ram_wr`  out  1  to RAM `wr`.
- `ram_response`  in  1  from RAM `response`.
- `ram_out`  in  DATA_W  from RAM `out`.
- `busy`  out  1  high in every state except IDLE.
- `grant`  out  1  index of the current or last granted port.

## Operation
- States:
  - IDLE: if `req0|req1`, pick a winner, latch its wr/addr/wdata, load the counter with WAIT_CYCLES-1, and go to ACCESS.
  - ACCESS: `ram_addr`, `ram_data` and `ram_wr` are driven from the latched values. Each edge with counter != 0 decrements the counter. The edge where counter == 0 and `ram_response` == 1 goes to DONE. If counter == 0 and `ram_response` == 0, the block stays in ACCESS indefinitely.
  - DONE: `ack[grant]` = 1 for exactly this cycle, `ram_wr` = 0, then IDLE.
- On the ACCESS->DONE edge of a read, `rdata[grant]` <= `ram_out`. Writes leave both rdata registers unchanged. The non-granted port's rdata never changes.
- Request inputs are sampled only in IDLE. Changes to addr/wdata/wr during ACCESS are ignored.
- Requester protocol: hold `req` and its fields stable until `ack`. A request dropped early is a protocol violation; the latched access still completes and `ack` still pulses.
- The arbiter does no address range checking. The full `ADDR_W` address is passed to the RAM.
- Reset values: state IDLE, `ack0`/`ack1` 0, `rdata0`/`rdata1` 0, `ram_addr` 0, `ram_data` 0, `ram_wr` 0, `busy` 0, `grant` 0, round-robin pointer = 1 (port 0 wins the first tie).
- Reset asserted mid-access: on the next edge the block returns to IDLE with all outputs at reset values. No `ack` is issued. A write in flight may or may not have landed.

## Timing
- A request seen in IDLE at edge E0 produces `ack` high in the cycle after edge E0+WAIT_CYCLES, provided `ram_response` is already 1.
- Minimum occupancy is WAIT_CYCLES+2 cycles per access (ACCESS + DONE + IDLE). With the default WAIT_CYCLES = 2, back-to-back requests get an `ack` every 4 cycles.
- `ram_wr` is high only in ACCESS cycles of a write. Repeated writes of the same word during those cycles are harmless.
- A request held high across its `ack` is re-arbitrated in the following IDLE cycle as a new access.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN` defined: round-robin. On a tie, the port not granted last wins, and the pointer updates on each grant.
- Not defined: fixed priority. Port 1 (load/store) always wins a tie, and no pointer register exists.
- Single-requester behaviour is identical in both builds.

## Structure
- Package `ram_arb_pkg` holds:
  - the state enum (IDLE, ACCESS, DONE);
  - port index constants `PORT_FETCH` = 0 and `PORT_LSU` = 1;
  - default width constants.
- Sub-module `ram_arb_pick` is combinational winner selection: inputs `req0`, `req1` and the last grant; output winner index. It contains the macro-dependent logic.

## Test plan
- Port 0 reads addr 5 with the RAM preloaded with 0xDEADBEEF at 5 and `ram_response` tied high -> `ack0` pulses exactly 3 cycles after `req0` is sampled, `rdata0` = 0xDEADBEEF, `rdata1` unchanged.
- Port 1 writes 0x12345678 to addr 9, then port 0 reads addr 9 -> `ram_wr` is high only during ACCESS, and `rdata0` = 0x12345678.
- `req0` and `req1` are held high together for 4 accesses:
  - with `RAM_ARB_ROUND_ROBIN_EN` -> grants alternate 0,1,0,1;
  - without the macro -> grants are 1,1,1,1.
- `ram_response` is forced low for 5 cycles after the counter expires -> the block stays in ACCESS with the bus stable, and `ack` rises the cycle after `ram_response` returns high.
- `addr0` changes from 3 to 7 during ACCESS -> `ram_addr` stays 3.
- `rst` is asserted in the second ACCESS cycle -> the next cycle shows IDLE, no `ack`, and `ram_wr`/`busy` = 0.
